// File: rtl/imem_pkg.sv
// Shared types and constants for the pipelined instruction/data memory.
package imem_pkg;

  typedef enum logic [0:0] {
    IMEM_CLEAR = 1'b0,
    IMEM_RUN   = 1'b1
  } imem_state_e;

  localparam int RD_LAT_MIN  = 1;
  localparam int RD_LAT_MAX  = 4;
  localparam int IMEM_DATA_W = 64;

  // Response at the default word width; instances with another DATA_W
  // declare the same layout at their own width.
  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [IMEM_DATA_W-1:0] rdata;
  } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_pipe.sv
// Response delay line: STAGES registers in series, cleared by reset so that
// in-flight responses are dropped.
module imem_rsp_pipe
  import imem_pkg::*;
#(
  parameter int  STAGES = 1,
  parameter type rsp_t  = imem_rsp_t
) (
  input  logic clk,
  input  logic rst_n,
  input  rsp_t head,
  output rsp_t tail
);

  if (STAGES < 1) begin : g_bad_stages
    $error("imem_rsp_pipe needs at least one stage");
  end

  rsp_t stage [STAGES];

  // Shift every response one stage further each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= head;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[STAGES-1];

endmodule

// File: rtl/imem_pipelined.sv
// Single-port memory with valid/ready requests, byte strobes, fixed read
// latency, out-of-range errors and a hardware clear sequencer.
module imem_pipelined
  import imem_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 64,
  parameter int RD_LAT         = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic                clear_req,
  output logic                busy,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  // One extra bit so the range check never wraps for any ADDR_W.
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam imem_state_e RESET_STATE = CLEAR_ON_RESET ? IMEM_CLEAR : IMEM_RUN;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("RD_LAT must lie in 1..4");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be at least 2");
  end
  if (ADDR_W < IDX_W) begin : g_bad_addr_w
    $error("ADDR_W too narrow to index DEPTH words");
  end

  imem_state_e       state, state_next;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  rsp_t              head, tail;

  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, req_addr} < DEPTH_EXT;
  assign idx       = req_addr[IDX_W-1:0];
  assign req_ready = rst_n && (state == IMEM_RUN);
  assign busy      = (state == IMEM_CLEAR);

  // Leave CLEAR after the last word is zeroed; enter it on a clear request.
  always_comb begin
    state_next = state;
    case (state)
      IMEM_CLEAR: if (clr_idx == LAST_IDX) state_next = IMEM_RUN;
      IMEM_RUN:   if (clear_req) state_next = IMEM_CLEAR;
      default:    state_next = RESET_STATE;
    endcase
  end

  // State register and clear counter; the counter idles at 0 outside CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET_STATE;
      clr_idx <= '0;
    end else begin
      state <= state_next;
      if (state == IMEM_CLEAR && clr_idx != LAST_IDX) clr_idx <= clr_idx + 1'b1;
      else clr_idx <= '0;
    end
  end

  // Storage array: zeroing during CLEAR, otherwise strobed in-range writes.
  always_ff @(posedge clk) begin
    if (state == IMEM_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (accept && req_write && in_range) begin
      for (int i = 0; i < STRB_W; i++)
        if (req_wstrb[i]) mem[idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
    end
  end

  // First response stage: registered read, zero data for writes and errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
    end else begin
      head.valid <= accept;
      head.err   <= accept && !in_range;
      head.rdata <= (accept && !req_write && in_range) ? mem[idx] : '0;
    end
  end

  if (RD_LAT > 1) begin : g_pipe
    imem_rsp_pipe #(
      .STAGES(RD_LAT - 1),
      .rsp_t (rsp_t)
    ) u_pipe (
      .clk  (clk),
      .rst_n(rst_n),
      .head (head),
      .tail (tail)
    );
  end else begin : g_direct
    assign tail = head;
  end

  assign rsp_valid = tail.valid;
  assign rsp_err   = tail.err;
  assign rsp_rdata = tail.rdata;

endmodule

// File: tb/tb_imem_pipelined.sv
// Two instances (read latency 1 and 3) share one stimulus stream; a bench
// memory model predicts every response and per-instance queues hold them.
module tb_imem_pipelined;

  localparam int DEPTH = 16;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        clear_req;

  logic        req_ready1, busy1, rsp_valid1, rsp_err1;
  logic [63:0] rsp_rdata1;
  logic        req_ready3, busy3, rsp_valid3, rsp_err3;
  logic [63:0] rsp_rdata3;

  logic [63:0] model [DEPTH];
  exp_t        q1[$];
  exp_t        q3[$];
  int          edge_count = 0;
  int          compares   = 0;
  int          fails      = 0;

  imem_pipelined #(
    .DATA_W(64), .DEPTH(DEPTH), .ADDR_W(64), .RD_LAT(1), .CLEAR_ON_RESET(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .clear_req(clear_req), .busy(busy1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  imem_pipelined #(
    .DATA_W(64), .DEPTH(DEPTH), .ADDR_W(64), .RD_LAT(3), .CLEAR_ON_RESET(1'b1)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .clear_req(clear_req), .busy(busy3),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compares++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one request for a cycle and queue its predicted response.
  task automatic applyStimulus(input logic wr, input logic [63:0] addr,
                               input logic [63:0] wd, input logic [7:0] ws,
                               input logic clr);
    exp_t e;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    clear_req = clr;
    if (req_ready1) begin
      e.err   = (addr >= 64'(DEPTH));
      e.rdata = 64'd0;
      if (!e.err && !wr) e.rdata = model[addr[3:0]];
      if (!e.err && wr)
        for (int i = 0; i < 8; i++)
          if (ws[i]) model[addr[3:0]][i*8 +: 8] = wd[i*8 +: 8];
      e.due = edge_count + 1;
      q1.push_back(e);
      e.due = edge_count + 3;
      q3.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic zeroModel();
    for (int i = 0; i < DEPTH; i++) model[i] = 64'd0;
  endtask

  // Count cycles until busy drops; optionally pulse clear_req mid-clear.
  task automatic waitClear(input string tag, input int pulse_at);
    int n = 0;
    while (busy1 && n < 200) begin
      clear_req = (n == pulse_at);
      @(negedge clk);
      n++;
    end
    clear_req = 1'b0;
    checkOutput({tag, "_len"}, 64'(n), 64'(DEPTH));
    checkOutput({tag, "_ready"}, 64'(req_ready1), 64'd1);
    checkOutput({tag, "_busy3"}, 64'(busy3), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready1"}, 64'(req_ready1), 64'd0);
    checkOutput({tag, "_valid1"}, 64'(rsp_valid1), 64'd0);
    checkOutput({tag, "_rdata1"}, rsp_rdata1, 64'd0);
    checkOutput({tag, "_err1"},   64'(rsp_err1),   64'd0);
    checkOutput({tag, "_busy1"},  64'(busy1),      64'd1);
    checkOutput({tag, "_ready3"}, 64'(req_ready3), 64'd0);
    checkOutput({tag, "_valid3"}, 64'(rsp_valid3), 64'd0);
    checkOutput({tag, "_rdata3"}, rsp_rdata3, 64'd0);
    checkOutput({tag, "_busy3"},  64'(busy3),      64'd1);
  endtask

  // Scoreboard for the latency-1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0 && q1[0].due <= edge_count) begin
      e = q1.pop_front();
      checkOutput("rsp1_valid", 64'(rsp_valid1), 64'd1);
      checkOutput("rsp1_rdata", rsp_rdata1, e.rdata);
      checkOutput("rsp1_err", 64'(rsp_err1), 64'(e.err));
    end else if (rsp_valid1) begin
      checkOutput("rsp1_spurious", 64'(rsp_valid1), 64'd0);
    end
  end

  // Scoreboard for the latency-3 instance.
  always @(negedge clk) begin
    exp_t e;
    if (q3.size() > 0 && q3[0].due <= edge_count) begin
      e = q3.pop_front();
      checkOutput("rsp3_valid", 64'(rsp_valid3), 64'd1);
      checkOutput("rsp3_rdata", rsp_rdata3, e.rdata);
      checkOutput("rsp3_err", 64'(rsp_err3), 64'(e.err));
    end else if (rsp_valid3) begin
      checkOutput("rsp3_spurious", 64'(rsp_valid3), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 64'd0;
    req_wdata = 64'd0;
    req_wstrb = 8'd0;
    clear_req = 1'b0;
    zeroModel();

    // Reset values, then the power-up clear.
    idle(2);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    waitClear("init_clear", -1);

    // Read after clear returns zero.
    applyStimulus(1'b0, 64'd5, 64'd0, 8'h00, 1'b0);
    idle(4);

    // Full write, lower-half strobed write, then read-after-write.
    applyStimulus(1'b1, 64'd3, 64'h1122334455667788, 8'hFF, 1'b0);
    applyStimulus(1'b1, 64'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0);
    applyStimulus(1'b0, 64'd3, 64'd0, 8'h00, 1'b0);
    idle(4);

    // Fill 0..7 back to back, then read them back back to back.
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 64'(i), {8{8'(i + 8'h30)}}, (i == 6) ? 8'h81 : 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 64'(i), 64'd0, 8'h00, 1'b0);
    idle(4);

    // Out-of-range addresses: error, no truncation, memory untouched.
    applyStimulus(1'b0, 64'(DEPTH), 64'd0, 8'h00, 1'b0);
    applyStimulus(1'b0, 64'h1_0000_0000, 64'd0, 8'h00, 1'b0);
    applyStimulus(1'b1, 64'(DEPTH), 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0);
    applyStimulus(1'b1, 64'h1_0000_0003, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 64'(i), 64'd0, 8'h00, 1'b0);
    idle(4);

    // Clear request together with an accepted read of addr 2.
    applyStimulus(1'b1, 64'd2, 64'h5, 8'hFF, 1'b0);
    idle(2);
    applyStimulus(1'b0, 64'd2, 64'd0, 8'h00, 1'b1);
    checkOutput("clr_busy_rise", 64'(busy1), 64'd1);
    checkOutput("clr_ready_low", 64'(req_ready1), 64'd0);
    zeroModel();
    waitClear("clr_req", 5);
    applyStimulus(1'b0, 64'd2, 64'd0, 8'h00, 1'b0);
    idle(4);

    // Reset while responses are in flight: they must vanish.
    applyStimulus(1'b1, 64'd4, 64'hDEADBEEF01234567, 8'hFF, 1'b0);
    idle(2);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'd4;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkResetOutputs("rst_inflight");
    idle(2);
    rst_n = 1'b1;
    zeroModel();

    // Reset again midway through the clear; it must restart from zero.
    idle(5);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst_midclear");
    @(negedge clk);
    rst_n = 1'b1;
    waitClear("rst_clear", -1);
    applyStimulus(1'b0, 64'd4, 64'd0, 8'h00, 1'b0);
    applyStimulus(1'b0, 64'd3, 64'd0, 8'h00, 1'b0);
    idle(6);

    checkOutput("q1_drained", 64'(q1.size()), 64'd0);
    checkOutput("q3_drained", 64'(q3.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
